// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response and memory-side signals of the shared memory port.
//   Requester side : if_* (instruction fetch), ls_* (load/store), flush_i, hlt_i
//   Memory side    : mem_en_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_rdata_i
//   slave modport  : the arbiter's view (consumes requests, drives grants and memory)
//   master modport : the surrounding pipeline/memory view
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR  = 16,
    parameter int unsigned W_OPR = 32
);
    logic              if_req_i;
    logic [ADDR-1:0]   if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [W_OPR-1:0]  if_rdata_o;
    logic              ls_req_i;
    logic              ls_write_i;
    logic [ADDR-1:0]   ls_addr_i;
    logic [W_OPR-1:0]  ls_wdata_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [W_OPR-1:0]  ls_rdata_o;
    logic              flush_i;
    logic              hlt_i;
    logic              mem_en_o;
    logic              mem_write_o;
    logic [ADDR-1:0]   mem_addr_o;
    logic [W_OPR-1:0]  mem_wdata_o;
    logic [W_OPR-1:0]  mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
               flush_i, hlt_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
               mem_en_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
               flush_i, hlt_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
               mem_en_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous (1-cycle read latency) memory port between
// instruction fetch and load/store. Load/store has priority; after STARVE_MAX consecutive
// denials of an eligible fetch, fetch is forced through. Read returns are tagged with the
// owner of the previous cycle's grant.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requests, grants, responses, memory drive)
module mem_port_arbiter #(
    parameter int unsigned ADDR       = 16,
    parameter int unsigned W_OPR      = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnLs} owner_e;

    owner_e           r_owner, w_owner_d;
    logic [3:0]       r_starve_cnt, w_starve_cnt_d;
    logic             r_halted, w_halted_d;

    logic             w_if_ok;
    logic             w_force;
    logic             w_if_gnt;
    logic             w_ls_gnt;
    logic             w_mem_write;
    logic [ADDR-1:0]  w_mem_addr;
    logic [W_OPR-1:0] w_mem_wdata;

    // Arbitration. Grants are qualified by reset so nothing is granted while it is held low.
    always_comb begin
        w_if_ok  = reset & bus.if_req_i & ~bus.flush_i & ~r_halted & ~bus.hlt_i;
        w_force  = (r_starve_cnt == StarveMax) & w_if_ok;
        w_ls_gnt = reset & bus.ls_req_i & ~w_force;
        w_if_gnt = w_if_ok & ~w_ls_gnt;
    end

    always_comb begin
        w_mem_write = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_ls_gnt) begin
            w_mem_write = bus.ls_write_i;
            w_mem_addr  = bus.ls_addr_i;
            w_mem_wdata = bus.ls_wdata_i;
        end else if (w_if_gnt) begin
            w_mem_addr  = bus.if_addr_i;
        end
    end

    always_comb begin
        w_starve_cnt_d = '0;
        w_owner_d      = OwnNone;
        w_halted_d     = r_halted | bus.hlt_i;
        // Only a fetch that was eligible yet denied counts toward starvation.
        if (w_if_ok && !w_if_gnt) begin
            w_starve_cnt_d = (r_starve_cnt == StarveMax) ? r_starve_cnt : r_starve_cnt + 4'd1;
        end
        // Stores produce no response, so they leave the owner at NONE.
        if (w_ls_gnt && !bus.ls_write_i) begin
            w_owner_d = OwnLs;
        end else if (w_if_gnt) begin
            w_owner_d = OwnIf;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= OwnNone;
            r_starve_cnt <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_owner      <= w_owner_d;
            r_starve_cnt <= w_starve_cnt_d;
            r_halted     <= w_halted_d;
        end
    end

    always_comb begin
        bus.if_gnt_o    = w_if_gnt;
        bus.ls_gnt_o    = w_ls_gnt;
        bus.mem_en_o    = w_if_gnt | w_ls_gnt;
        bus.mem_write_o = w_mem_write;
        bus.mem_addr_o  = w_mem_addr;
        bus.mem_wdata_o = w_mem_wdata;
        bus.ls_rvalid_o = (r_owner == OwnLs);
        bus.ls_rdata_o  = (r_owner == OwnLs) ? bus.mem_rdata_i : '0;
        // A flush in the return cycle drops the fetch data; the port was already freed.
        bus.if_rvalid_o = (r_owner == OwnIf) & ~bus.flush_i;
        bus.if_rdata_o  = ((r_owner == OwnIf) && !bus.flush_i) ? bus.mem_rdata_i : '0;
    end
endmodule
